// File: rtl/i_serdes_pkg.sv
// Shared definitions for the input deserializer: FSM states, legal WIDTH
// range and counter widths.
package i_serdes_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } state_t;

    localparam int WIDTH_MIN    = 3;
    localparam int WIDTH_MAX    = 10;
    localparam int BIT_CNT_W    = $clog2(WIDTH_MAX);
    localparam int SETTLE_CNT_W = 8;

endpackage

// File: rtl/i_serdes_deser_if.sv
// Fabric/pad-side signal bundle of the input deserializer.
//   slave  : deserializer side (control/serial inputs in, word stream out)
//   master : driving side (pad, PLL and fabric logic)
// Signals: PLL_LOCK, EN, D, BITSLIP, CHANNEL_BOND_SYNC_IN, DATA_READY (to DUT);
//          Q[WIDTH], DATA_VALID, CHANNEL_BOND_SYNC_OUT, OVERFLOW (from DUT).
interface i_serdes_deser_if #(
    parameter int WIDTH = 4
);
    logic             PLL_LOCK;
    logic             EN;
    logic             D;
    logic             BITSLIP;
    logic             CHANNEL_BOND_SYNC_IN;
    logic             DATA_READY;
    logic [WIDTH-1:0] Q;
    logic             DATA_VALID;
    logic             CHANNEL_BOND_SYNC_OUT;
    logic             OVERFLOW;

    modport master (
        output PLL_LOCK, EN, D, BITSLIP, CHANNEL_BOND_SYNC_IN, DATA_READY,
        input  Q, DATA_VALID, CHANNEL_BOND_SYNC_OUT, OVERFLOW
    );

    modport slave (
        input  PLL_LOCK, EN, D, BITSLIP, CHANNEL_BOND_SYNC_IN, DATA_READY,
        output Q, DATA_VALID, CHANNEL_BOND_SYNC_OUT, OVERFLOW
    );
endinterface

// File: rtl/i_serdes_word_fifo.sv
// Show-ahead word FIFO for the deserializer.
// Ports: clk_i, rst_i (async, active-high), flush_i (synchronous clear),
//        push_i/wdata_i, pop_i, rdata_o (head word), full_o, empty_o.
// A push while full is accepted only when a pop happens on the same edge.
module i_serdes_word_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "i_serdes_word_fifo: DEPTH must be a power of two >= 2");
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/i_serdes_deser.sv
// Input deserializer: samples D on CLK_IN (MSB first), assembles WIDTH-bit
// words with BITSLIP / channel-bond alignment and queues them in a FIFO.
// Ports: CLK_IN (bit clock), RST (async, active-high),
//        bus (slave modport: control/serial inputs, Q/DATA_VALID/
//        CHANNEL_BOND_SYNC_OUT/OVERFLOW outputs).
module i_serdes_deser
    import i_serdes_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_DELAY = 8,
    parameter int FIFO_DEPTH = 4
) (
    input logic             CLK_IN,
    input logic             RST,
    i_serdes_deser_if.slave bus
);
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $fatal(1, "i_serdes_deser: WIDTH must be in 3..10");
    end
    if (LOCK_DELAY < 1 || LOCK_DELAY > 255) begin : g_bad_delay
        $fatal(1, "i_serdes_deser: LOCK_DELAY must be in 1..255");
    end

    localparam logic [BIT_CNT_W-1:0]    LAST_BIT   = BIT_CNT_W'(WIDTH - 1);
    localparam logic [SETTLE_CNT_W-1:0] LAST_SETTLE = SETTLE_CNT_W'(LOCK_DELAY - 1);

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        shift_q, shift_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SETTLE_CNT_W-1:0] settle_q, settle_d;
    logic                    bitslip_q;
    logic                    sync_out_q;
    logic                    overflow_q;
    logic                    slip_edge;
    logic                    push;
    logic                    flush;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic [WIDTH-1:0]        head;

    assign slip_edge = bus.BITSLIP && !bitslip_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        settle_d  = settle_q;
        push      = 1'b0;
        flush     = 1'b0;
        if (!bus.PLL_LOCK) begin
            // Loss of lock from any state drops pending bits and queued words.
            state_d   = WAIT_LOCK;
            shift_d   = '0;
            bit_cnt_d = '0;
            settle_d  = '0;
            flush     = 1'b1;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
                SETTLE: begin
                    if (settle_q == LAST_SETTLE) state_d = RUN;
                    else                         settle_d = settle_q + 1'b1;
                end
                RUN: begin
                    if (bus.EN) begin
                        if (bus.CHANNEL_BOND_SYNC_IN) begin
                            shift_d   = {{(WIDTH-1){1'b0}}, bus.D};
                            bit_cnt_d = BIT_CNT_W'(1);
                        end else if (!slip_edge) begin
                            // A slip edge swallows D, moving the boundary one bit later.
                            shift_d = {shift_q[WIDTH-2:0], bus.D};
                            if (bit_cnt_q == LAST_BIT) begin
                                push      = 1'b1;
                                bit_cnt_d = '0;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = WAIT_LOCK;
            endcase
        end
    end

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            state_q    <= WAIT_LOCK;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            settle_q   <= '0;
            bitslip_q  <= 1'b0;
            sync_out_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            settle_q   <= settle_d;
            bitslip_q  <= bus.BITSLIP;
            sync_out_q <= push;
            overflow_q <= overflow_q | (push && full && !pop);
        end
    end

    assign pop = !empty && bus.DATA_READY;

    i_serdes_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK_IN),
        .rst_i   (RST),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i (shift_d),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.Q                     = empty ? '0 : head;
    assign bus.DATA_VALID            = !empty;
    assign bus.CHANNEL_BOND_SYNC_OUT = sync_out_q;
    assign bus.OVERFLOW              = overflow_q;
endmodule

// File: doc/i_serdes_deser.md
Name: i_serdes_deser

Overview:
- Input deserializer; the receive-side counterpart of the output serializer in the GBOX primitive set.
- Samples a single-bit serial stream on one clock, MSB first, and assembles WIDTH-bit words.
- Provides word-boundary alignment through BITSLIP and channel-bond sync, and buffers words in a 4-entry FIFO with a valid/ready handshake toward the fabric.
- Sits between the input pad/I_DELAY and fabric logic.

Parameters:
WIDTH, 4, deserialized word width; legal 3-10, otherwise $fatal at elaboration.
LOCK_DELAY, 8, cycles to wait after PLL_LOCK is seen before sampling starts; legal 1-255.
FIFO_DEPTH, 4, word buffer depth; fixed power of two.

Ports:
CLK_IN  in  1  serial bit clock; all logic on posedge.
RST  in  1  reset; asynchronous, active-high.
PLL_LOCK  in  1  clock-source lock indication.
EN  in  1  sample enable; 0 freezes the shift path.
D  in  1  serial data input.
BITSLIP  in  1  word-alignment request; acts on its rising edge.
CHANNEL_BOND_SYNC_IN  in  1  forces a word boundary.
DATA_READY  in  1  fabric accepts the head word.
Q  out  WIDTH  head word of the FIFO.
DATA_VALID  out  1  Q is valid.
CHANNEL_BOND_SYNC_OUT  out  1  word-boundary pulse.
OVERFLOW  out  1  sticky word-drop flag.

Behaviour:
- Reset (RST=1, async): FSM=WAIT_LOCK; shift register, bit counter, settle counter and FIFO pointers all 0. Outputs after reset: Q=0, DATA_VALID=0, CHANNEL_BOND_SYNC_OUT=0, OVERFLOW=0.
- FSM:
  - WAIT_LOCK -> SETTLE on an edge with PLL_LOCK=1.
  - SETTLE counts edges 0..LOCK_DELAY-1, then -> RUN.
  - Any state -> WAIT_LOCK on an edge with PLL_LOCK=0. On that transition: shift register, bit counter and FIFO are cleared; OVERFLOW is retained.
- RUN, EN=1, per edge, in priority order:
  1. CHANNEL_BOND_SYNC_IN=1: partial word discarded; D taken as bit 0 of a new word; bit_cnt=1.
  2. BITSLIP rising edge (BITSLIP=1 and registered previous value=0): D discarded; shift register and bit_cnt hold. The word boundary moves one bit later.
  3. Otherwise: shift_reg <= {shift_reg[WIDTH-2:0], D}; bit_cnt++.
- Word completion: bit_cnt==WIDTH-1 and a shift occurs. Word {shift_reg[WIDTH-2:0], D} is pushed to the FIFO on that same edge; bit_cnt -> 0. The first serial bit lands in Q[WIDTH-1].
- EN=0: shift register and bit_cnt hold; BITSLIP edge detector still updates, so the pulse is lost; SYNC is ignored.
- CHANNEL_BOND_SYNC_OUT: registered; high for exactly the one cycle after each word-completion edge.
- FIFO:
  - Show-ahead. DATA_VALID = !empty; Q = head word when valid, else 0.
  - Pop on an edge with DATA_VALID && DATA_READY.
  - Latency: last bit sampled at edge n -> DATA_VALID=1 after edge n if the FIFO was empty.
  - Full, push and pop on the same edge: both occur; occupancy unchanged.
  - Full, push, no pop: word dropped; OVERFLOW <= 1 (sticky until RST).
  - Pointers wrap modulo FIFO_DEPTH; an extra occupancy bit distinguishes full from empty.
- Reset mid-word or mid-drain: immediate clear; no partial word is ever emitted.

Decomposition:
- Package i_serdes_pkg: FSM state enum (WAIT_LOCK, SETTLE, RUN), WIDTH_MIN=3, WIDTH_MAX=10, counter width constants (bit counter $clog2(WIDTH_MAX), settle counter 8 bits).
- One sub-module: i_serdes_word_fifo. Parameterised WIDTH/DEPTH, show-ahead, synchronous flush input, async active-high reset, push/pop/full/empty ports.

Test Plan:
(All scenarios use WIDTH=4, LOCK_DELAY=8, DATA_READY=1 unless noted.)
1. Lock/settle: RST pulse, then PLL_LOCK=1 -> all outputs 0 during reset; no shift occurs for the lock-seen edge plus 8 settle edges; the first sampled bit is on edge 10 after PLL_LOCK is seen.
2. Serial 1,0,1,0,0,0,1,1 -> Q=4'hA, DATA_VALID for 1 cycle, then Q=4'h3. CHANNEL_BOND_SYNC_OUT pulses one cycle after each 4th bit.
3. Repeating 0,1,0,0 stream -> Q=4'h4 each word. One BITSLIP 0->1 pulse -> subsequent words Q=4'h8. Holding BITSLIP high causes no further slips.
4. DATA_READY=0; stream words 1,2,3,4,5 -> FIFO holds 1,2,3,4; OVERFLOW=1 after the 5th word edge. Raise DATA_READY -> Q=1,2,3,4 on consecutive cycles, then DATA_VALID=0; OVERFLOW stays 1.
5. Two bits 1,1 then CHANNEL_BOND_SYNC_IN=1 with D=0, followed by 1,1,0 -> partial word discarded; next word Q=4'h6.
6. PLL_LOCK drops with 2 words queued and 2 bits pending -> DATA_VALID=0 after that edge; no word emitted; OVERFLOW unchanged. Re-lock -> 8-cycle settle, then a clean first word.
